// File: rtl/arm_pkg.sv
// -----------------------------------------------------------------------------
// arm_pkg
// Shared types and widths for the ARM pipeline stages.
//   DATA_W      : datapath width (32)
//   REG_ID_W    : register-file index width (4)
//   mem_state_t : MEM-stage access sequencer states
//   exe_mem_t   : fields held in the EXE/MEM pipeline register
//   mem_wb_t    : fields held in the MEM/WB pipeline register
// -----------------------------------------------------------------------------
package arm_pkg;

   localparam int DATA_W   = 32;
   localparam int REG_ID_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } mem_state_t;

   typedef struct packed {
      logic                wb_en;
      logic                mem_r_en;
      logic                mem_w_en;
      logic [DATA_W-1:0]   alu_result;
      logic [DATA_W-1:0]   val_rm;
      logic [REG_ID_W-1:0] dest;
   } exe_mem_t;

   typedef struct packed {
      logic                wb_en;
      logic                mem_r_en;
      logic [DATA_W-1:0]   alu_result;
      logic [DATA_W-1:0]   mem_read_value;
      logic [REG_ID_W-1:0] dest;
      logic                addr_err;
   } mem_wb_t;

endpackage

// File: rtl/data_mem.sv
// -----------------------------------------------------------------------------
// data_mem
// Synchronous DEPTH x DATA_W word array, one write port and one registered
// read port sharing a single address. No reset: contents survive pipeline
// reset. When read and write hit the same edge, rdata captures the word as it
// was before the write.
//   clk   in   clock, rising edge
//   we    in   write enable
//   re    in   read enable (rdata holds its value when low)
//   addr  in   word index
//   wdata in   write data
//   rdata out  registered read data
// -----------------------------------------------------------------------------
module data_mem
   import arm_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int IDX_W = 6
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [IDX_W-1:0]  addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// ARM pipeline MEM stage. Holds the EXE/MEM register, sequences loads and
// stores against an internal data memory with WAIT_CYCLES extra wait states,
// drives the MEM/WB register and exposes EXE/MEM contents as forwarding taps.
// freeze stalls the upstream pipeline while an access is in flight.
//   clk             in   clock, rising edge
//   rst             in   asynchronous reset, active low
//   WB_EN_in        in   write-back enable from EXE
//   MEM_R_EN_in     in   load from EXE
//   MEM_W_EN_in     in   store from EXE
//   ALU_result_in   in   ALU result / byte address from EXE
//   val_Rm_in       in   store data from EXE
//   Dest_in         in   destination register from EXE
//   freeze          out  stall request to upstream registers / hazard unit
//   fwd_WB_EN       out  EXE/MEM WB_EN tap
//   fwd_Dest        out  EXE/MEM Dest tap
//   fwd_ALU_Res     out  EXE/MEM ALU result tap
//   WB_EN_out       out  MEM/WB write-back enable
//   MEM_R_EN_out    out  MEM/WB load flag
//   ALU_result_out  out  MEM/WB ALU result
//   Mem_read_value  out  MEM/WB load data
//   Dest_out        out  MEM/WB destination register
//   addr_err        out  MEM/WB out-of-range access flag
// -----------------------------------------------------------------------------
module mem_stage
   import arm_pkg::*;
#(
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 3,
   parameter int ADDR_BASE   = 1024
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                WB_EN_in,
   input  logic                MEM_R_EN_in,
   input  logic                MEM_W_EN_in,
   input  logic [DATA_W-1:0]   ALU_result_in,
   input  logic [DATA_W-1:0]   val_Rm_in,
   input  logic [REG_ID_W-1:0] Dest_in,
   output logic                freeze,
   output logic                fwd_WB_EN,
   output logic [REG_ID_W-1:0] fwd_Dest,
   output logic [DATA_W-1:0]   fwd_ALU_Res,
   output logic                WB_EN_out,
   output logic                MEM_R_EN_out,
   output logic [DATA_W-1:0]   ALU_result_out,
   output logic [DATA_W-1:0]   Mem_read_value,
   output logic [REG_ID_W-1:0] Dest_out,
   output logic                addr_err
);

   localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W      = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam int CNT_INIT_I = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CNT_INIT_I);

   exe_mem_t          exe_mem_p0;
   exe_mem_t          exe_mem_d;
   mem_wb_t           mem_wb_p1;
   mem_wb_t           mem_wb_d;
   mem_state_t        state_q;
   mem_state_t        state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;

   logic              mem_op;
   logic              access;
   logic [DATA_W:0]   addr_diff;
   logic [DATA_W-3:0] word_idx;
   logic              out_of_range;
   logic              mem_we;
   logic              mem_re;
   logic [DATA_W-1:0] rd_buf;
   logic              unused_addr_lsbs;

   // ---- EXE/MEM register input ----
   always_comb begin
      exe_mem_d            = '0;
      exe_mem_d.wb_en      = WB_EN_in;
      exe_mem_d.mem_r_en   = MEM_R_EN_in;
      exe_mem_d.mem_w_en   = MEM_W_EN_in;
      exe_mem_d.alu_result = ALU_result_in;
      exe_mem_d.val_rm     = val_Rm_in;
      exe_mem_d.dest       = Dest_in;
   end

   assign mem_op = exe_mem_p0.mem_r_en | exe_mem_p0.mem_w_en;

   // One extra MSB in the subtraction exposes an address below ADDR_BASE as a
   // set borrow bit; the byte offset within a word is dropped.
   assign addr_diff        = {1'b0, exe_mem_p0.alu_result} - (DATA_W+1)'(ADDR_BASE);
   assign word_idx         = addr_diff[DATA_W-1:2];
   assign unused_addr_lsbs = ^addr_diff[1:0];
   assign out_of_range     = addr_diff[DATA_W] | (word_idx >= (DATA_W-2)'(DEPTH));

   // ---- access sequencer ----
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      freeze  = 1'b0;
      access  = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_op) begin
               freeze = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  access  = 1'b1;
                  state_d = DONE;
               end else begin
                  cnt_d   = CNT_INIT;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            freeze = 1'b1;
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               access  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Out-of-range accesses never reach the array: stores vanish and the load
   // result is forced to zero below.
   assign mem_we = access & exe_mem_p0.mem_w_en & ~out_of_range;
   assign mem_re = access & exe_mem_p0.mem_r_en & ~out_of_range;

   data_mem #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_data_mem (
      .clk   (clk),
      .we    (mem_we),
      .re    (mem_re),
      .addr  (word_idx[IDX_W-1:0]),
      .wdata (exe_mem_p0.val_rm),
      .rdata (rd_buf)
   );

   // ---- MEM/WB register input ----
   // While frozen a bubble is written so the instruction reaches WB only once,
   // on the edge that leaves DONE (or the single edge of a non-memory op).
   always_comb begin
      mem_wb_d = '0;
      if (!freeze) begin
         mem_wb_d.wb_en      = exe_mem_p0.wb_en;
         mem_wb_d.mem_r_en   = exe_mem_p0.mem_r_en;
         mem_wb_d.alu_result = exe_mem_p0.alu_result;
         mem_wb_d.dest       = exe_mem_p0.dest;
         mem_wb_d.addr_err   = mem_op & out_of_range;
         if ((state_q == DONE) && exe_mem_p0.mem_r_en && !out_of_range) begin
            mem_wb_d.mem_read_value = rd_buf;
         end
      end
   end

   // ---- pipeline registers and sequencer state ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         exe_mem_p0 <= '0;
         mem_wb_p1  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mem_wb_p1 <= mem_wb_d;
         if (!freeze) begin
            exe_mem_p0 <= exe_mem_d;
         end
      end
   end

   // ---- outputs ----
   assign fwd_WB_EN      = exe_mem_p0.wb_en;
   assign fwd_Dest       = exe_mem_p0.dest;
   assign fwd_ALU_Res    = exe_mem_p0.alu_result;

   assign WB_EN_out      = mem_wb_p1.wb_en;
   assign MEM_R_EN_out   = mem_wb_p1.mem_r_en;
   assign ALU_result_out = mem_wb_p1.alu_result;
   assign Mem_read_value = mem_wb_p1.mem_read_value;
   assign Dest_out       = mem_wb_p1.dest;
   assign addr_err       = mem_wb_p1.addr_err;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- ARM pipeline MEM stage, directly downstream of the EXE stage.
- Holds the EXE/MEM pipeline register and performs loads/stores against an internal word-addressed data memory with a configurable wait-state latency.
- Drives the MEM/WB register and exposes the forwarding taps that feed the EXE stage's ALU_Res forwarding path.
- Asserts freeze to stall the upstream pipeline while a memory access is in flight.

Parameters:
- DEPTH, 64: number of 32-bit data memory words.
- WAIT_CYCLES, 3: extra wait cycles per memory access (0 allowed).
- ADDR_BASE, 1024: byte address that maps to word 0.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- WB_EN_in  in  1  write-back enable from EXE.
- MEM_R_EN_in  in  1  load from EXE.
- MEM_W_EN_in  in  1  store from EXE.
- ALU_result_in  in  32  ALU result / byte address from EXE.
- val_Rm_in  in  32  store data (forwarded Rm) from EXE.
- Dest_in  in  4  destination register from EXE.
- freeze  out  1  stall request to IF/ID/EXE registers and hazard unit.
- fwd_WB_EN  out  1  EXE/MEM register WB_EN, forwarding tap.
- fwd_Dest  out  4  EXE/MEM register Dest, forwarding tap.
- fwd_ALU_Res  out  32  EXE/MEM register ALU result, forwarding tap (ALU_Res input of EXE).
- WB_EN_out  out  1  MEM/WB register.
- MEM_R_EN_out  out  1  MEM/WB register.
- ALU_result_out  out  32  MEM/WB register.
- Mem_read_value  out  32  MEM/WB register, load data.
- Dest_out  out  4  MEM/WB register.
- addr_err  out  1  MEM/WB register, out-of-range access flag.

Behaviour:
- Reset (rst=0, async): every output and register is 0, FSM=IDLE, wait counter=0. Memory contents are not reset.
- S is the EXE/MEM register. It loads all *_in on posedge when freeze=0 and holds when freeze=1. Upstream holds its inputs while freeze=1.
- mem_op = S.MEM_R_EN | S.MEM_W_EN.
- Word index = (S.ALU_result − ADDR_BASE) >> 2. Bits [1:0] are ignored.
- Out of range when the subtraction underflows or index ≥ DEPTH. Such a store is dropped; such a load returns 0; addr_err=1 for that instruction.
- FSM states IDLE, WAIT, DONE:
  - IDLE, mem_op=0: stay IDLE; freeze=0; single-cycle pass-through.
  - IDLE, mem_op=1, WAIT_CYCLES>0: go to WAIT, cnt←WAIT_CYCLES−1; freeze=1.
  - IDLE, mem_op=1, WAIT_CYCLES=0: perform access at this edge, go to DONE; freeze=1.
  - WAIT: freeze=1. If cnt≠0, cnt decrements. If cnt=0, perform access at this edge and go to DONE.
  - DONE: freeze=0; go to IDLE. S accepts the next instruction on this edge.
- Access at that edge:
  - Store: mem[index]←S.val_Rm.
  - Load: rd_buf←mem[index].
  - Both enables set: store commits, and rd_buf captures the pre-write word.
- Memory op occupancy is WAIT_CYCLES+2 cycles. Non-memory op occupancy is 1 cycle.
- MEM/WB register:
  - freeze=0: loads S fields. Mem_read_value←rd_buf in DONE, else 0.
  - freeze=1: loads a bubble, all fields 0. An instruction therefore reaches WB exactly once.
- Forwarding taps are combinational copies of S and are valid during freeze.
- Reset asserted mid-access: FSM to IDLE, pending store is lost unless its commit edge already occurred, freeze drops to 0 immediately.

Decomposition:
- Shared package arm_pkg holds:
  - mem_state_t enum {IDLE, WAIT, DONE}.
  - exe_mem_t and mem_wb_t packed structs for the stage register fields.
  - DATA_W=32 and REG_ID_W=4.
- One sub-module: data_mem, the synchronous DEPTH×32 array with a write port and a registered read port, no reset.
- FSM, counter and pipeline registers stay in mem_stage.

Test Plan:
- Reset: hold rst=0 with random inputs → all outputs 0, freeze=0. Release, then drive a non-memory op (WB_EN=1, Dest=5, ALU_result=7) → one cycle later WB_EN_out=1, Dest_out=5, ALU_result_out=7, freeze never 1.
- Store then load, WAIT_CYCLES=3: store val_Rm=0xDEADBEEF to addr 1028 → freeze high exactly 4 cycles. Then load 1028 → freeze high 4 cycles, then Mem_read_value=0xDEADBEEF, MEM_R_EN_out=1, exactly one non-bubble WB cycle.
- WAIT_CYCLES=0 build: load addr 1024 → freeze high exactly 1 cycle, data returns the next cycle.
- Out of range: load addr 1020 and load addr 1024+4·DEPTH → Mem_read_value=0, addr_err=1. Store to 1020 → no memory word changes.
- Forwarding during stall: load with Dest=3, ALU_result=1032 held under freeze → fwd_Dest=3, fwd_ALU_Res=1032, fwd_WB_EN=1 on every frozen cycle; upstream inputs changing during freeze are not captured.
- Reset mid-WAIT: assert rst during the second WAIT cycle of a store to 1036 → freeze=0 asynchronously, mem[3] unchanged, next instruction passes normally.
